// File: rtl/ping_sensor_model.sv
// ping_sensor_model: sensor-side emulator for the single-pin ultrasonic ranging link.
// Optional build macro PING_MODEL_NOECHO_EN: distance 0 means "no object" and yields the timeout echo.
module ping_sensor_model #(
  parameter int WIDTH         = 16,
  parameter int CYCLES_PER_MM = 292,
  parameter int MIN_TRIG      = 100,
  parameter int MAX_TRIG      = 1000,
  parameter int HOLDOFF_CYC   = 37500,
  parameter int MIN_ECHO      = 5750,
  parameter int MAX_ECHO      = 925000,
  parameter int GUARD_CYC     = 10000
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire              sensor,
  input  logic [WIDTH-1:0] distance,
  output logic             driving,
  output logic [2:0]       state,
  output logic [7:0]       trig_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG    = 3'd1,
    HOLDOFF = 3'd2,
    ECHO    = 3'd3,
    GUARD   = 3'd4,
    STUCK   = 3'd5
  } state_t;

  localparam int CPM_W  = $clog2(CYCLES_PER_MM + 1);
  localparam int PROD_W = WIDTH + ((CPM_W > 10) ? CPM_W : 10);
  localparam int EXT_W  = (PROD_W > 24) ? PROD_W : 24;
  localparam int TW     = $clog2(MAX_TRIG + 1);

  state_t            st;
  logic              sync1;
  logic              s_in;
  logic              line_q;
  logic [TW-1:0]     wcnt;
  logic [23:0]       cnt;
  logic [WIDTH-1:0]  dist_q;
  logic [PROD_W-1:0] prod_q;
  logic [EXT_W-1:0]  prod_ext;
  logic [23:0]       echo_cyc;

  // Enable and data both come straight from flops, so nothing upstream can glitch the line.
  assign sensor = driving ? line_q : 1'bz;
  assign state  = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      s_in  <= 1'b0;
    end else begin
      sync1 <= sensor;
      s_in  <= sync1;
    end
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    prod_ext = EXT_W'(prod_q);
    echo_cyc = 24'(MIN_ECHO);
    if (prod_ext > EXT_W'(MAX_ECHO))
      echo_cyc = 24'(MAX_ECHO);
    else if (prod_ext > EXT_W'(MIN_ECHO))
      echo_cyc = prod_ext[23:0];
`ifdef PING_MODEL_NOECHO_EN
    if (dist_q == '0)
      echo_cyc = 24'(MAX_ECHO);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= IDLE;
      driving    <= 1'b0;
      line_q     <= 1'b0;
      wcnt       <= '0;
      cnt        <= '0;
      dist_q     <= '0;
      prod_q     <= '0;
      trig_count <= '0;
    end else begin
      case (st)
        IDLE: begin
          driving <= 1'b0;
          if (s_in) begin
            st   <= TRIG;
            wcnt <= '0;
          end
        end
        TRIG: begin
          if (!s_in) begin
            if (wcnt >= TW'(MIN_TRIG)) begin
              st         <= HOLDOFF;
              dist_q     <= distance;
              trig_count <= trig_count + 8'd1;
              driving    <= 1'b1;
              line_q     <= 1'b0;
              cnt        <= 24'(HOLDOFF_CYC - 1);
            end else begin
              st <= IDLE;
            end
          end else if (wcnt == TW'(MAX_TRIG - 1)) begin
            st <= STUCK;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        HOLDOFF: begin
          // The product settles early in the holdoff window and is only consumed at its end.
          prod_q <= PROD_W'(dist_q) * PROD_W'(CYCLES_PER_MM);
          if (cnt == '0) begin
            st     <= ECHO;
            line_q <= 1'b1;
            cnt    <= echo_cyc - 24'd1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ECHO: begin
          if (cnt == '0) begin
            st      <= GUARD;
            driving <= 1'b0;
            line_q  <= 1'b0;
            cnt     <= 24'(GUARD_CYC - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GUARD: begin
          if (cnt == '0)
            st <= IDLE;
          else
            cnt <= cnt - 1'b1;
        end
        STUCK: begin
          if (!s_in)
            st <= IDLE;
        end
        default: begin
          st      <= IDLE;
          driving <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ping_sensor_model.sv
// Directed bench for ping_sensor_model using scaled-down timing parameters so every scenario runs quickly.
module tb_ping_sensor_model;

  localparam int CPM      = 3;
  localparam int MIN_TRIG = 10;
  localparam int MAX_TRIG = 40;
  localparam int HOLD     = 50;
  localparam int MIN_ECHO = 30;
  localparam int MAX_ECHO = 600;
  localparam int GUARD    = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] distance = '0;
  logic        host_drive = 1'b0;
  logic        host_val = 1'b0;
  wire         sensor;
  logic        driving;
  logic [2:0]  state;
  logic [7:0]  trig_count;

  int          n_pass = 0;
  int          n_total = 0;
  logic [7:0]  exp_count = '0;

  assign sensor = host_drive ? host_val : 1'bz;
  pulldown (sensor);

  always #10 clk = ~clk;

  ping_sensor_model #(
    .WIDTH(16), .CYCLES_PER_MM(CPM), .MIN_TRIG(MIN_TRIG), .MAX_TRIG(MAX_TRIG),
    .HOLDOFF_CYC(HOLD), .MIN_ECHO(MIN_ECHO), .MAX_ECHO(MAX_ECHO), .GUARD_CYC(GUARD)
  ) dut (
    .clk(clk), .reset(reset), .sensor(sensor), .distance(distance),
    .driving(driving), .state(state), .trig_count(trig_count)
  );

  task automatic host_pulse(input int width);
    host_drive = 1'b1;
    host_val   = 1'b1;
    repeat (width) @(negedge clk);
    host_drive = 1'b0;
    host_val   = 1'b0;
  endtask

  // Measures the response that follows a host release; widths are counted in clock cycles.
  task automatic measure(output int hold, output int echo, output int guard, output bit seen);
    int n = 0;
    hold = 0; echo = 0; guard = 0;
    while (!driving && n < 20) begin @(negedge clk); n++; end
    seen = driving;
    if (seen) begin
      while (driving && sensor === 1'b0 && hold < 2000) begin hold++; @(negedge clk); end
      while (driving && sensor === 1'b1 && echo < 2000) begin echo++; @(negedge clk); end
      while (state === 3'd4 && guard < 2000) begin guard++; @(negedge clk); end
    end
  endtask

  task automatic watch_idle(input int cycles, output bit drove);
    drove = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (driving !== 1'b0) drove = 1'b1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_total++; if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
    n_total++; if (driving !== 1'b0) $display("FAIL reset_driving: got %b want 0", driving); else n_pass++;
    n_total++; if (trig_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", trig_count); else n_pass++;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_total++; if (sensor !== 1'b0 || state !== 3'd0)
      $display("FAIL post_reset_idle: sensor %b state %0d want 0/0", sensor, state); else n_pass++;
  endtask

  task automatic test_basic;
    int h, e, g; bit seen;
    distance = 16'd86;
    host_pulse(25); exp_count++;
    measure(h, e, g, seen);
    n_total++; if (seen !== 1'b1) $display("FAIL basic_seen: got %b want 1", seen); else n_pass++;
    n_total++; if (h != HOLD) $display("FAIL basic_holdoff: got %0d want %0d", h, HOLD); else n_pass++;
    n_total++; if (e != 258) $display("FAIL basic_echo: got %0d want 258", e); else n_pass++;
    n_total++; if (g != GUARD) $display("FAIL basic_guard: got %0d want %0d", g, GUARD); else n_pass++;
    n_total++; if (trig_count !== exp_count)
      $display("FAIL basic_count: got %0d want %0d", trig_count, exp_count); else n_pass++;
  endtask

  task automatic test_clamp;
    int h, e, g; bit seen;
    distance = 16'd4;
    host_pulse(20); exp_count++;
    measure(h, e, g, seen);
    n_total++; if (e != MIN_ECHO) $display("FAIL clamp_low: got %0d want %0d", e, MIN_ECHO); else n_pass++;
    distance = 16'd4000;
    host_pulse(20); exp_count++;
    measure(h, e, g, seen);
    n_total++; if (e != MAX_ECHO) $display("FAIL clamp_high: got %0d want %0d", e, MAX_ECHO); else n_pass++;
    distance = 16'd150;
    host_pulse(20); exp_count++;
    measure(h, e, g, seen);
    n_total++; if (e != 450) $display("FAIL mid_range: got %0d want 450", e); else n_pass++;
    n_total++; if (trig_count !== exp_count)
      $display("FAIL clamp_count: got %0d want %0d", trig_count, exp_count); else n_pass++;
  endtask

  task automatic test_distance_change;
    int h, e, g; bit seen;
    distance = 16'd86;
    host_pulse(20); exp_count++;
    repeat (5) @(negedge clk);
    distance = 16'd1000;
    measure(h, e, g, seen);
    n_total++; if (e != 258) $display("FAIL latched_distance: got %0d want 258", e); else n_pass++;
  endtask

  task automatic test_short_trigger;
    bit drove;
    distance = 16'd86;
    host_pulse(5);
    watch_idle(30, drove);
    n_total++; if (drove !== 1'b0) $display("FAIL short_no_drive: got %b want 0", drove); else n_pass++;
    n_total++; if (state !== 3'd0) $display("FAIL short_state: got %0d want 0", state); else n_pass++;
    n_total++; if (trig_count !== exp_count)
      $display("FAIL short_count: got %0d want %0d", trig_count, exp_count); else n_pass++;
  endtask

  task automatic test_stuck;
    bit d1, d2;
    host_drive = 1'b1; host_val = 1'b1;
    watch_idle(60, d1);
    n_total++; if (state !== 3'd5) $display("FAIL stuck_state: got %0d want 5", state); else n_pass++;
    watch_idle(30, d2);
    host_drive = 1'b0; host_val = 1'b0;
    repeat (6) @(negedge clk);
    n_total++; if (state !== 3'd0) $display("FAIL stuck_release: got %0d want 0", state); else n_pass++;
    n_total++; if ((d1 | d2) !== 1'b0) $display("FAIL stuck_no_drive: got %b want 0", d1 | d2); else n_pass++;
    n_total++; if (trig_count !== exp_count)
      $display("FAIL stuck_count: got %0d want %0d", trig_count, exp_count); else n_pass++;
  endtask

  task automatic test_zero_distance;
    int h, e, g, want; bit seen;
`ifdef PING_MODEL_NOECHO_EN
    want = MAX_ECHO;
`else
    want = MIN_ECHO;
`endif
    distance = 16'd0;
    host_pulse(20); exp_count++;
    measure(h, e, g, seen);
    n_total++; if (e != want) $display("FAIL zero_distance: got %0d want %0d", e, want); else n_pass++;
  endtask

  task automatic test_reset_mid_echo;
    int h, e, g, n; bit seen;
    distance = 16'd4000;
    host_pulse(20); exp_count++;
    n = 0;
    while (!(driving && sensor === 1'b1) && n < 200) begin @(negedge clk); n++; end
    n_total++; if (state !== 3'd3) $display("FAIL reach_echo: got %0d want 3", state); else n_pass++;
    repeat (100) @(negedge clk);
    #3 reset = 1'b1;
    #1;
    n_total++; if (driving !== 1'b0) $display("FAIL async_driving: got %b want 0", driving); else n_pass++;
    n_total++; if (state !== 3'd0) $display("FAIL async_state: got %0d want 0", state); else n_pass++;
    n_total++; if (sensor !== 1'b0) $display("FAIL async_line: got %b want released", sensor); else n_pass++;
    n_total++; if (trig_count !== 8'd0) $display("FAIL async_count: got %0d want 0", trig_count); else n_pass++;
    exp_count = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    distance = 16'd86;
    host_pulse(25); exp_count++;
    measure(h, e, g, seen);
    n_total++; if (e != 258) $display("FAIL after_reset_echo: got %0d want 258", e); else n_pass++;
    n_total++; if (trig_count !== exp_count)
      $display("FAIL after_reset_count: got %0d want %0d", trig_count, exp_count); else n_pass++;
  endtask

  // Raises the host line during GUARD and releases it `after` cycles past GUARD exit.
  task automatic retrigger_in_guard(input int after);
    int n = 0;
    distance = 16'd86;
    host_pulse(20); exp_count++;
    while (state !== 3'd4 && n < 2000) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    host_drive = 1'b1; host_val = 1'b1;
    n = 0;
    while (state === 3'd4 && n < 200) begin @(negedge clk); n++; end
    repeat (after) @(negedge clk);
    host_drive = 1'b0; host_val = 1'b0;
  endtask

  task automatic test_back_to_back;
    int h, e, g; bit seen, drove;
    retrigger_in_guard(20); exp_count++;
    measure(h, e, g, seen);
    n_total++; if (seen !== 1'b1) $display("FAIL b2b_seen: got %b want 1", seen); else n_pass++;
    n_total++; if (e != 258) $display("FAIL b2b_echo: got %0d want 258", e); else n_pass++;
    n_total++; if (trig_count !== exp_count)
      $display("FAIL b2b_count: got %0d want %0d", trig_count, exp_count); else n_pass++;
    retrigger_in_guard(3);
    watch_idle(30, drove);
    n_total++; if (drove !== 1'b0) $display("FAIL b2b_short_drive: got %b want 0", drove); else n_pass++;
    n_total++; if (state !== 3'd0) $display("FAIL b2b_short_state: got %0d want 0", state); else n_pass++;
    n_total++; if (trig_count !== exp_count)
      $display("FAIL b2b_short_count: got %0d want %0d", trig_count, exp_count); else n_pass++;
  endtask

  task automatic test_wrap;
    int h, e, g, bad; bit seen;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_count = '0;
    bad = 0;
    distance = 16'd4;
    repeat (255) begin
      host_pulse(15); exp_count++;
      measure(h, e, g, seen);
      if (!seen || e != MIN_ECHO) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL wrap_responses: got %0d bad want 0", bad); else n_pass++;
    n_total++; if (trig_count !== 8'd255) $display("FAIL count_255: got %0d want 255", trig_count); else n_pass++;
    host_pulse(15); exp_count++;
    measure(h, e, g, seen);
    n_total++; if (trig_count !== exp_count)
      $display("FAIL count_wrap: got %0d want %0d", trig_count, exp_count); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_clamp;
    test_distance_change;
    test_short_trigger;
    test_stuck;
    test_zero_distance;
    test_reset_mid_echo;
    test_back_to_back;
    test_wrap;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
